// File: rtl/alarm_ring_controller_if.sv
// ----------------------------------------------------------------------------
// alarm_ring_controller_if
//   Bundles the timekeeping/timer/button inputs and the speaker/status outputs
//   of the alarm ring controller.
//   master : drives the inputs, observes the outputs (time base, buttons, bench)
//   slave  : the controller itself
//   Signals:
//     tick_1hz      one-cycle pulse per second
//     current_time  BCD HHMMSS
//     alarm_time    BCD HHMMSS, 24'h000000 means no alarm set
//     alarm_arm     alarm enabled (level)
//     timer_done    countdown timer at zero (level)
//     btn_snooze    debounced one-cycle pulse
//     btn_dismiss   debounced one-cycle pulse
//     speaker_out   square-wave tone or 0
//     ring_src      00 none, 01 alarm, 10 timer
//     snooze_active 1 while snoozing
//     snooze_cnt    snoozes used in the current alarm event
// ----------------------------------------------------------------------------
interface alarm_ring_controller_if;
  logic        tick_1hz;
  logic [23:0] current_time;
  logic [23:0] alarm_time;
  logic        alarm_arm;
  logic        timer_done;
  logic        btn_snooze;
  logic        btn_dismiss;
  logic        speaker_out;
  logic [1:0]  ring_src;
  logic        snooze_active;
  logic [1:0]  snooze_cnt;

  modport master (
    output tick_1hz, current_time, alarm_time, alarm_arm, timer_done,
           btn_snooze, btn_dismiss,
    input  speaker_out, ring_src, snooze_active, snooze_cnt
  );

  modport slave (
    input  tick_1hz, current_time, alarm_time, alarm_arm, timer_done,
           btn_snooze, btn_dismiss,
    output speaker_out, ring_src, snooze_active, snooze_cnt
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// ----------------------------------------------------------------------------
// alarm_ring_controller
//   Drives the alarm clock speaker. Detects the alarm match and timer expiry,
//   arbitrates the two ring sources (alarm has priority), and handles snooze
//   and dismiss with a BCD snooze wake time, a snooze limit and a ring timeout.
//   Ports:
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  alarm_ring_controller_if.slave (inputs from timekeeping/timer/
//          buttons, speaker and status outputs)
//   Build option:
//     ALARM_ESCALATE_EN  when defined, the alarm tone doubles in pitch once
//                        the ring has lasted half of RING_TIMEOUT_S.
// ----------------------------------------------------------------------------
module alarm_ring_controller #(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned MAX_SNOOZE     = 3,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned ALARM_TONE_BIT = 13,
  parameter int unsigned TIMER_TONE_BIT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  alarm_ring_controller_if.slave  bus
);

  // Encoding chosen so the ring states equal their ring_src code.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ALARM  = 2'b01;
  localparam logic [1:0] ST_TIMER  = 2'b10;
  localparam logic [1:0] ST_SNOOZE = 2'b11;

  localparam logic [7:0] TIMEOUT      = 8'(RING_TIMEOUT_S);
  localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);
  localparam logic [3:0] SNOOZE_ADD   = 4'(SNOOZE_MIN);

  logic [1:0]  state_q, state_d;
  logic [15:0] tone_q, tone_d;
  logic [7:0]  ring_sec_q, ring_sec_d;
  logic [23:0] snooze_time_q, snooze_time_d;
  logic [1:0]  snooze_cnt_q, snooze_cnt_d;
  logic        match_q, match_d;
  logic        timer_q, timer_d;
  logic        timer_pend_q, timer_pend_d;
  logic        snooze_pend_q, snooze_pend_d;
  logic        speaker_q, speaker_d;

  logic        alarm_hit, timer_hit, ring_timeout, snooze_req, pend_now;
  logic [4:0]  mo_sum;
  logic [3:0]  mt_sum, ho_sum, ht_sum;
  logic        hr_carry;
  logic [23:0] snooze_sum;

  // Edge detectors: one alarm hit per matching second, one timer hit per rise.
  assign match_d   = bus.alarm_arm && (bus.alarm_time != 24'h000000) &&
                     (bus.current_time == bus.alarm_time);
  assign timer_d   = bus.timer_done;
  assign alarm_hit = match_d && !match_q;
  assign timer_hit = bus.timer_done && !timer_q;
  assign tone_d    = tone_q + 16'd1;

  assign ring_timeout = (ring_sec_q >= TIMEOUT);
  // A timeout behaves exactly like a snooze press.
  assign snooze_req   = bus.btn_snooze || ring_timeout;
  assign pend_now     = timer_pend_q || timer_hit;

  // Snooze wake time: current_time + SNOOZE_MIN minutes, digit-wise BCD.
  always_comb begin
    mo_sum   = {1'b0, bus.current_time[11:8]} + {1'b0, SNOOZE_ADD};
    mt_sum   = bus.current_time[15:12];
    ho_sum   = bus.current_time[19:16];
    ht_sum   = bus.current_time[23:20];
    hr_carry = 1'b0;
    if (mo_sum > 5'd9) begin
      mo_sum = mo_sum - 5'd10;
      mt_sum = mt_sum + 4'd1;
    end
    if (mt_sum > 4'd5) begin
      mt_sum   = 4'd0;
      hr_carry = 1'b1;
    end
    if (hr_carry) begin
      if (ht_sum == 4'd2 && ho_sum == 4'd3) begin
        ht_sum = 4'd0;
        ho_sum = 4'd0;
      end else if (ho_sum == 4'd9) begin
        ho_sum = 4'd0;
        ht_sum = ht_sum + 4'd1;
      end else begin
        ho_sum = ho_sum + 4'd1;
      end
    end
    snooze_sum = {ht_sum, ho_sum, mt_sum, mo_sum[3:0], bus.current_time[7:0]};
  end

  // Ring sequencing.
  always_comb begin
    state_d       = state_q;
    snooze_cnt_d  = snooze_cnt_q;
    snooze_time_d = snooze_time_q;
    timer_pend_d  = timer_pend_q;
    snooze_pend_d = snooze_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_hit) begin
          state_d      = ST_ALARM;
          snooze_cnt_d = 2'd0;
          timer_pend_d = timer_hit;
        end else if (timer_hit) begin
          state_d = ST_TIMER;
        end
      end
      ST_ALARM: begin
        // Dismiss wins over snooze; a snooze beyond the limit is a dismiss.
        if (!bus.alarm_arm || bus.btn_dismiss ||
            (snooze_req && snooze_cnt_q >= SNOOZE_LIMIT)) begin
          timer_pend_d = 1'b0;
          state_d      = (pend_now && bus.timer_done) ? ST_TIMER : ST_IDLE;
        end else if (snooze_req) begin
          state_d       = ST_SNOOZE;
          snooze_cnt_d  = snooze_cnt_q + 2'd1;
          snooze_time_d = snooze_sum;
          timer_pend_d  = pend_now;
        end else begin
          timer_pend_d  = pend_now;
        end
      end
      ST_SNOOZE: begin
        if (!bus.alarm_arm || bus.btn_dismiss) begin
          state_d       = ST_IDLE;
          snooze_pend_d = 1'b0;
        end else if (timer_hit) begin
          // The snooze resumes once the timer ring is finished.
          state_d       = ST_TIMER;
          snooze_pend_d = 1'b1;
        end else if (bus.current_time == snooze_time_q) begin
          state_d = ST_ALARM;
        end
      end
      default: begin // ST_TIMER
        if (alarm_hit) begin
          // New alarm event preempts; the timer rings again afterwards.
          state_d       = ST_ALARM;
          snooze_cnt_d  = 2'd0;
          timer_pend_d  = 1'b1;
          snooze_pend_d = 1'b0;
        end else if (bus.btn_dismiss || ring_timeout) begin
          state_d       = snooze_pend_q ? ST_SNOOZE : ST_IDLE;
          snooze_pend_d = 1'b0;
        end
      end
    endcase
  end

  // Ring seconds restart whenever a ring state is entered; saturate at 255.
  always_comb begin
    ring_sec_d = ring_sec_q;
    if ((state_d == ST_ALARM || state_d == ST_TIMER) && state_d != state_q) begin
      ring_sec_d = 8'd0;
    end else if ((state_q == ST_ALARM || state_q == ST_TIMER) &&
                 bus.tick_1hz && ring_sec_q != 8'hFF) begin
      ring_sec_d = ring_sec_q + 8'd1;
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam logic [7:0] HALF_TIMEOUT = 8'(RING_TIMEOUT_S / 2);
`endif

  always_comb begin
    speaker_d = 1'b0;
    case (state_q)
`ifdef ALARM_ESCALATE_EN
      ST_ALARM: speaker_d = (ring_sec_q >= HALF_TIMEOUT) ? tone_q[ALARM_TONE_BIT-1]
                                                         : tone_q[ALARM_TONE_BIT];
`else
      ST_ALARM: speaker_d = tone_q[ALARM_TONE_BIT];
`endif
      ST_TIMER: speaker_d = tone_q[TIMER_TONE_BIT];
      default:  speaker_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tone_q        <= 16'd0;
      ring_sec_q    <= 8'd0;
      snooze_time_q <= 24'd0;
      snooze_cnt_q  <= 2'd0;
      match_q       <= 1'b0;
      timer_q       <= 1'b0;
      timer_pend_q  <= 1'b0;
      snooze_pend_q <= 1'b0;
      speaker_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tone_q        <= tone_d;
      ring_sec_q    <= ring_sec_d;
      snooze_time_q <= snooze_time_d;
      snooze_cnt_q  <= snooze_cnt_d;
      match_q       <= match_d;
      timer_q       <= timer_d;
      timer_pend_q  <= timer_pend_d;
      snooze_pend_q <= snooze_pend_d;
      speaker_q     <= speaker_d;
    end
  end

  assign bus.speaker_out   = speaker_q;
  assign bus.ring_src      = (state_q == ST_SNOOZE) ? ST_IDLE : state_q;
  assign bus.snooze_active = (state_q == ST_SNOOZE);
  assign bus.snooze_cnt    = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// ----------------------------------------------------------------------------
// tb_alarm_ring_controller
//   Vector table for the basic ring/snooze/timer transitions, followed by
//   hand-written sequences for tone period, BCD snooze wrap, snooze limit,
//   ring timeouts, timer/snooze interplay and reset while ringing.
//   Expected outputs are queued when a transaction is driven and popped and
//   compared one clock later, when the DUT has produced them.
// ----------------------------------------------------------------------------
module tb_alarm_ring_controller;
  logic clk = 1'b0;
  logic rst;

  alarm_ring_controller_if bus();

  alarm_ring_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  typedef struct {
    string      name;
    logic [1:0] src;
    logic       sa;
    logic [1:0] cnt;
    bit         chk_cnt;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [23:0] cur;
    logic [23:0] alm;
    logic        arm;
    logic        tdone;
    logic        snz;
    logic        dis;
    logic        tick;
    logic [1:0]  src;
    logic        sa;
    logic [1:0]  cnt;
    bit          chk_cnt;
  } vec_t;

  vec_t vecs[14];

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    bus.btn_snooze  = 1'b0;
    bus.btn_dismiss = 1'b0;
    bus.tick_1hz    = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [1:0] src,
                            input logic sa, input logic [1:0] cnt, input bit chk_cnt);
    exp_t e;
    e.name = name; e.src = src; e.sa = sa; e.cnt = cnt; e.chk_cnt = chk_cnt;
    sb_q.push_back(e);
  endtask

  task automatic compare_one();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    if (bus.ring_src !== e.src || bus.snooze_active !== e.sa ||
        (e.chk_cnt && bus.snooze_cnt !== e.cnt)) begin
      errors++;
      $display("FAIL %s: got ring_src=%b snooze_active=%b snooze_cnt=%0d, need ring_src=%b snooze_active=%b snooze_cnt=%0d%s",
               e.name, bus.ring_src, bus.snooze_active, bus.snooze_cnt,
               e.src, e.sa, e.cnt, e.chk_cnt ? "" : "(any)");
    end else begin
      $display("ok   %s: ring_src=%b snooze_active=%b snooze_cnt=%0d",
               e.name, bus.ring_src, bus.snooze_active, bus.snooze_cnt);
    end
  endtask

  task automatic step(input string name, input logic [1:0] src, input logic sa,
                      input logic [1:0] cnt, input bit chk_cnt);
    expect_out(name, src, sa, cnt, chk_cnt);
    cyc();
    compare_one();
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tick_1hz = 1'b1;
      cyc();
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.tick_1hz     = 1'b0;
    bus.current_time = 24'h000000;
    bus.alarm_time   = 24'h000000;
    bus.alarm_arm    = 1'b0;
    bus.timer_done   = 1'b0;
    bus.btn_snooze   = 1'b0;
    bus.btn_dismiss  = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t_first;
    int t_second;
    int toggles;
    logic prev;
    logic [23:0] wake [3];

    vecs[0]  = '{24'h065959, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{24'h070000, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{24'h070000, 24'h070000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 1'b1};
    vecs[3]  = '{24'h070000, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 1'b1};
    vecs[4]  = '{24'h070500, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd1, 1'b1};
    vecs[5]  = '{24'h070500, 24'h070000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{24'h070500, 24'h070000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{24'h070500, 24'h070000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{24'h070500, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{24'h070000, 24'h070000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b1};
    vecs[10] = '{24'h070000, 24'h070000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{24'h070001, 24'h070000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};
    vecs[12] = '{24'h070000, 24'h070000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0};

    wake[0] = 24'h070500;
    wake[1] = 24'h071000;
    wake[2] = 24'h071500;

    @(negedge clk);
    do_reset();
    check_int("reset_speaker", int'(bus.speaker_out), 0);
    step("reset_idle", 2'b00, 1'b0, 2'd0, 1'b1);

    // Vector table: single-cycle transactions.
    for (int i = 0; i < 14; i++) begin
      bus.current_time = vecs[i].cur;
      bus.alarm_time   = vecs[i].alm;
      bus.alarm_arm    = vecs[i].arm;
      bus.timer_done   = vecs[i].tdone;
      bus.btn_snooze   = vecs[i].snz;
      bus.btn_dismiss  = vecs[i].dis;
      bus.tick_1hz     = vecs[i].tick;
      expect_out($sformatf("vec%0d", i), vecs[i].src, vecs[i].sa, vecs[i].cnt, vecs[i].chk_cnt);
      cyc();
      compare_one();
    end

    // Alarm tone period and single hit per matching second.
    bus.alarm_time = 24'h070000;
    bus.alarm_arm = 1'b1;
    bus.current_time = 24'h065959;
    step("t1_before", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h070000;
    step("t1_hit", 2'b01, 1'b0, 2'd0, 1'b1);
    prev = bus.speaker_out;
    toggles = 0;
    t_first = -1;
    t_second = -1;
    for (int k = 0; k < 20000 && toggles < 2; k++) begin
      cyc();
      if (bus.speaker_out !== prev) begin
        if (toggles == 0) t_first = cyc_n;
        else t_second = cyc_n;
        toggles++;
        prev = bus.speaker_out;
      end
    end
    check_int("t1_tone_half_period", (toggles == 2) ? (t_second - t_first) : -1, 8192);
    bus.btn_dismiss = 1'b1;
    step("t1_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step($sformatf("t1_hold%0d", k), 2'b00, 1'b0, 2'd0, 1'b0);
    end
    check_int("t1_speaker_idle", int'(bus.speaker_out), 0);

    // Timer expires during alarm: alarm keeps priority, timer follows dismiss.
    bus.current_time = 24'h070001;
    step("t4_idle", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h070000;
    step("t4_alarm", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.timer_done = 1'b1;
    step("t4_timer_rise", 2'b01, 1'b0, 2'd0, 1'b1);
    step("t4_still_alarm", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("t4_to_timer", 2'b10, 1'b0, 2'd0, 1'b0);
    bus.timer_done = 1'b0;
    bus.btn_dismiss = 1'b1;
    step("t4_timer_off", 2'b00, 1'b0, 2'd0, 1'b0);

    // BCD snooze wake time across midnight, hour and tens-of-hours.
    bus.alarm_time = 24'h235830;
    bus.current_time = 24'h235829;
    step("t2_pre", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h235830;
    step("t2_ring", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.btn_snooze = 1'b1;
    step("t2_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    step("t2_wait", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h000329;
    step("t2_early", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h000330;
    step("t2_wake_0003", 2'b01, 1'b0, 2'd1, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("t2_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);

    bus.alarm_time = 24'h095500;
    bus.current_time = 24'h095459;
    step("t2b_pre", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h095500;
    step("t2b_ring", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.btn_snooze = 1'b1;
    step("t2b_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h100000;
    step("t2b_wake_1000", 2'b01, 1'b0, 2'd1, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("t2b_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);

    bus.alarm_time = 24'h195800;
    bus.current_time = 24'h195759;
    step("t2c_pre", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h195800;
    step("t2c_ring", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.btn_snooze = 1'b1;
    step("t2c_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h200300;
    step("t2c_wake_2003", 2'b01, 1'b0, 2'd1, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("t2c_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);

    // Snooze limit, then a fresh alarm event restarts the snooze count.
    bus.alarm_time = 24'h070000;
    bus.current_time = 24'h060000;
    step("t3_pre", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h070000;
    step("t3_ring", 2'b01, 1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.btn_snooze = 1'b1;
      step($sformatf("t3_snooze%0d", k + 1), 2'b00, 1'b1, 2'(k + 1), 1'b1);
      bus.current_time = wake[k];
      step($sformatf("t3_wake%0d", k + 1), 2'b01, 1'b0, 2'(k + 1), 1'b1);
    end
    bus.btn_snooze = 1'b1;
    step("t3_snooze4_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h060000;
    step("t3_idle", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h070000;
    step("t3_new_event", 2'b01, 1'b0, 2'd0, 1'b1);

    // Ring timeout: alarm auto-snoozes, counter restarts on re-entry.
    tick_n(59);
    bus.tick_1hz = 1'b1;
    step("t5_tick60", 2'b01, 1'b0, 2'd0, 1'b1);
    step("t5_auto_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h070500;
    step("t5_rering", 2'b01, 1'b0, 2'd1, 1'b1);
    tick_n(59);
    step("t5_no_early_timeout", 2'b01, 1'b0, 2'd1, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("t5_dismiss", 2'b00, 1'b0, 2'd0, 1'b0);

    // Timer timeout returns to idle.
    bus.timer_done = 1'b1;
    step("t5_timer", 2'b10, 1'b0, 2'd0, 1'b0);
    tick_n(59);
    bus.tick_1hz = 1'b1;
    step("t5_timer_tick60", 2'b10, 1'b0, 2'd0, 1'b0);
    step("t5_timer_timeout", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.timer_done = 1'b0;

    // Timer during snooze, snooze resumes after timer dismiss.
    bus.current_time = 24'h060000;
    step("tp_pre", 2'b00, 1'b0, 2'd0, 1'b0);
    bus.current_time = 24'h070000;
    step("tp_ring", 2'b01, 1'b0, 2'd0, 1'b1);
    bus.btn_snooze = 1'b1;
    step("tp_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.timer_done = 1'b1;
    step("tp_timer", 2'b10, 1'b0, 2'd1, 1'b1);
    bus.btn_dismiss = 1'b1;
    step("tp_back_to_snooze", 2'b00, 1'b1, 2'd1, 1'b1);
    bus.current_time = 24'h070500;
    step("tp_wake", 2'b01, 1'b0, 2'd1, 1'b1);

    // Reset while ringing.
    rst = 1'b1;
    step("t6_reset_mid_ring", 2'b00, 1'b0, 2'd0, 1'b1);
    check_int("t6_reset_speaker", int'(bus.speaker_out), 0);
    rst = 1'b0;
    bus.timer_done = 1'b0;
    step("t6_after_reset", 2'b00, 1'b0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
